// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath (master) and the stall sequencer (slave).
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs_addr;
  logic [4:0]       id_rt_addr;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_valid;
  logic             ex_wb_wen;
  logic [4:0]       ex_regw_addr;
  logic             mem_valid;
  logic             mem_wb_wen;
  logic [4:0]       mem_regw_addr;
  logic             wb_valid;
  logic             wb_wen;
  logic [4:0]       wb_regw_addr;
  logic             mem_req;
  logic             dmem_ack;
  logic             mem_redirect;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_raw;
  logic [CNT_W-1:0] cnt_mem;
  logic [CNT_W-1:0] cnt_flush;
  logic             mem_tmo_err;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           ex_valid, ex_wb_wen, ex_regw_addr, mem_valid, mem_wb_wen, mem_regw_addr,
           wb_valid, wb_wen, wb_regw_addr, mem_req, dmem_ack, mem_redirect,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, state, cnt_raw, cnt_mem, cnt_flush, mem_tmo_err
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           ex_valid, ex_wb_wen, ex_regw_addr, mem_valid, mem_wb_wen, mem_regw_addr,
           wb_valid, wb_wen, wb_regw_addr, mem_req, dmem_ack, mem_redirect,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, state, cnt_raw, cnt_mem, cnt_flush, mem_tmo_err
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage interlocked pipeline: RAW stalls, data-memory
// wait with timeout release, MEM-stage redirect flushes, and saturating per-cause counters.
module pipeline_stall_ctrl #(
  parameter bit WB_BYPASS   = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAW_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  cnt_raw_q, cnt_mem_q, cnt_flush_q;
  logic              tmo_err_q;

  logic hit_rs, hit_rt, raw, tmo, mem_pending, memwait;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush;
  logic do_raw, do_mem, do_redirect;

  function automatic logic dest_hit(input logic v, input logic w,
                                    input logic [4:0] d, input logic [4:0] r);
    return v & w & (d == r);
  endfunction

  always_comb begin
    hit_rs = dest_hit(bus.ex_valid, bus.ex_wb_wen, bus.ex_regw_addr, bus.id_rs_addr)
           | dest_hit(bus.mem_valid, bus.mem_wb_wen, bus.mem_regw_addr, bus.id_rs_addr)
           | (!WB_BYPASS & dest_hit(bus.wb_valid, bus.wb_wen, bus.wb_regw_addr, bus.id_rs_addr));
    hit_rt = dest_hit(bus.ex_valid, bus.ex_wb_wen, bus.ex_regw_addr, bus.id_rt_addr)
           | dest_hit(bus.mem_valid, bus.mem_wb_wen, bus.mem_regw_addr, bus.id_rt_addr)
           | (!WB_BYPASS & dest_hit(bus.wb_valid, bus.wb_wen, bus.wb_regw_addr, bus.id_rt_addr));
    raw = bus.id_valid & ((bus.id_rs_used & (bus.id_rs_addr != 5'd0) & hit_rs)
                        | (bus.id_rt_used & (bus.id_rt_addr != 5'd0) & hit_rt));
  end

  // At the timeout count the access is released exactly as if dmem_ack had arrived.
  assign tmo         = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign mem_pending = bus.mem_valid & bus.mem_req & ~bus.dmem_ack;
  assign memwait     = mem_pending & ~tmo;

  always_comb begin
    state_d     = RUN;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    do_raw      = 1'b0;
    do_mem      = 1'b0;
    do_redirect = 1'b0;
    if (!rst) begin
      if (memwait) begin
        state_d     = MEM_WAIT;
        do_mem      = 1'b1;
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (bus.mem_redirect) begin
        state_d     = RUN;
        do_redirect = 1'b1;
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        {ifid_flush, idex_flush, exmem_flush}         = '1;
      end else if (raw) begin
        state_d    = RAW_STALL;
        do_raw     = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      cnt_raw_q   <= '0;
      cnt_mem_q   <= '0;
      cnt_flush_q <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= do_mem ? wait_cnt + 1'b1 : '0;
      if (mem_pending && tmo)
        tmo_err_q <= 1'b1;
      if (do_raw && cnt_raw_q != '1)
        cnt_raw_q <= cnt_raw_q + 1'b1;
      if (do_mem && cnt_mem_q != '1)
        cnt_mem_q <= cnt_mem_q + 1'b1;
      if (do_redirect && cnt_flush_q != '1)
        cnt_flush_q <= cnt_flush_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_en    = memwb_en;
  assign bus.memwb_flush = memwb_flush;
  assign bus.state       = state_q;
  assign bus.cnt_raw     = cnt_raw_q;
  assign bus.cnt_mem     = cnt_mem_q;
  assign bus.cnt_flush   = cnt_flush_q;
  assign bus.mem_tmo_err = tmo_err_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two instances (WB bypass / 16-bit counters, and no bypass /
// short timeout / 4-bit counters) share one stimulus and are checked against a reference model.
module tb_pipeline_stall_ctrl;
  localparam logic [8:0] C_RUN = 9'b110101010;
  localparam logic [8:0] C_RAW = 9'b000111010;
  localparam logic [8:0] C_MEM = 9'b000000011;
  localparam logic [8:0] C_RED = 9'b111111110;
  localparam logic [8:0] C_RST = 9'b000000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(16)) if_a ();
  pipeline_stall_ctrl_if #(.CNT_W(4))  if_b ();

  pipeline_stall_ctrl #(.WB_BYPASS(1'b1), .MEM_TIMEOUT(16), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  pipeline_stall_ctrl #(.WB_BYPASS(1'b0), .MEM_TIMEOUT(4), .CNT_W(4))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  assign if_b.id_valid      = if_a.id_valid;
  assign if_b.id_rs_addr    = if_a.id_rs_addr;
  assign if_b.id_rt_addr    = if_a.id_rt_addr;
  assign if_b.id_rs_used    = if_a.id_rs_used;
  assign if_b.id_rt_used    = if_a.id_rt_used;
  assign if_b.ex_valid      = if_a.ex_valid;
  assign if_b.ex_wb_wen     = if_a.ex_wb_wen;
  assign if_b.ex_regw_addr  = if_a.ex_regw_addr;
  assign if_b.mem_valid     = if_a.mem_valid;
  assign if_b.mem_wb_wen    = if_a.mem_wb_wen;
  assign if_b.mem_regw_addr = if_a.mem_regw_addr;
  assign if_b.wb_valid      = if_a.wb_valid;
  assign if_b.wb_wen        = if_a.wb_wen;
  assign if_b.wb_regw_addr  = if_a.wb_regw_addr;
  assign if_b.mem_req       = if_a.mem_req;
  assign if_b.dmem_ack      = if_a.dmem_ack;
  assign if_b.mem_redirect  = if_a.mem_redirect;

  typedef struct {
    logic rst, idv; logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu;
    logic exv, exw; logic [4:0] exd;
    logic memv, memw; logic [4:0] memd;
    logic wbv, wbw; logic [4:0] wbd;
    logic req, ack, redir;
  } stim_t;

  typedef struct { stim_t s; logic [8:0] exp_a; logic [8:0] exp_b; string name; } vec_t;

  typedef struct {
    int bypass; int tmo; int cmax;
    int wait_n; bit err; int craw; int cmem; int cfl; int st;
  } mdl_t;

  mdl_t ma, mb;
  int checks = 0;
  int failures = 0;

  function automatic stim_t mk(logic r, logic idv, int rs, logic rsu, int rt, logic rtu,
                               logic exv, logic exw, int exd, logic memv, logic memw, int memd,
                               logic wbv, logic wbw, int wbd, logic req, logic ack, logic redir);
    stim_t s;
    s.rst = r; s.idv = idv; s.rs = 5'(rs); s.rsu = rsu; s.rt = 5'(rt); s.rtu = rtu;
    s.exv = exv; s.exw = exw; s.exd = 5'(exd);
    s.memv = memv; s.memw = memw; s.memd = 5'(memd);
    s.wbv = wbv; s.wbw = wbw; s.wbd = 5'(wbd);
    s.req = req; s.ack = ack; s.redir = redir;
    return s;
  endfunction

  function automatic mdl_t mdl_init(int bypass, int tmo, int cntw);
    mdl_t m;
    m.bypass = bypass; m.tmo = tmo; m.cmax = (1 << cntw) - 1;
    m.wait_n = 0; m.err = 1'b0; m.craw = 0; m.cmem = 0; m.cfl = 0; m.st = 0;
    return m;
  endfunction

  // cause: 0 run, 1 raw, 2 memory wait, 3 redirect, 4 reset
  function automatic void mdl_eval(input mdl_t m, input stim_t s,
                                   output logic [8:0] ctl, output int cause);
    int writers[$];
    bit raw;
    if (s.rst) begin
      ctl = C_RST; cause = 4;
      return;
    end
    if (s.exv && s.exw) writers.push_back(int'(s.exd));
    if (s.memv && s.memw) writers.push_back(int'(s.memd));
    if (m.bypass == 0 && s.wbv && s.wbw) writers.push_back(int'(s.wbd));
    raw = 1'b0;
    foreach (writers[i]) begin
      if (s.rsu && s.rs != 0 && writers[i] == int'(s.rs)) raw = 1'b1;
      if (s.rtu && s.rt != 0 && writers[i] == int'(s.rt)) raw = 1'b1;
    end
    raw = raw && s.idv;
    if (s.memv && s.req && !s.ack && m.wait_n != m.tmo - 1) begin ctl = C_MEM; cause = 2; end
    else if (s.redir) begin ctl = C_RED; cause = 3; end
    else if (raw)     begin ctl = C_RAW; cause = 1; end
    else              begin ctl = C_RUN; cause = 0; end
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, stim_t s, int cause);
    mdl_t n = m;
    if (cause == 4) return mdl_init(m.bypass, m.tmo, $clog2(m.cmax + 1));
    if (s.memv && s.req && !s.ack && m.wait_n == m.tmo - 1) n.err = 1'b1;
    n.wait_n = (cause == 2) ? m.wait_n + 1 : 0;
    if (cause == 1 && n.craw < n.cmax) n.craw++;
    if (cause == 2 && n.cmem < n.cmax) n.cmem++;
    if (cause == 3 && n.cfl < n.cmax) n.cfl++;
    n.st = (cause == 2) ? 2 : (cause == 1) ? 1 : 0;
    return n;
  endfunction

  function automatic logic [8:0] ctl_a();
    return {if_a.pc_en, if_a.ifid_en, if_a.ifid_flush, if_a.idex_en, if_a.idex_flush,
            if_a.exmem_en, if_a.exmem_flush, if_a.memwb_en, if_a.memwb_flush};
  endfunction

  function automatic logic [8:0] ctl_b();
    return {if_b.pc_en, if_b.ifid_en, if_b.ifid_flush, if_b.idex_en, if_b.idex_flush,
            if_b.exmem_en, if_b.exmem_flush, if_b.memwb_en, if_b.memwb_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    rst = s.rst;
    if_a.id_valid = s.idv;   if_a.id_rs_addr = s.rs;   if_a.id_rs_used = s.rsu;
    if_a.id_rt_addr = s.rt;  if_a.id_rt_used = s.rtu;
    if_a.ex_valid = s.exv;   if_a.ex_wb_wen = s.exw;   if_a.ex_regw_addr = s.exd;
    if_a.mem_valid = s.memv; if_a.mem_wb_wen = s.memw; if_a.mem_regw_addr = s.memd;
    if_a.wb_valid = s.wbv;   if_a.wb_wen = s.wbw;      if_a.wb_regw_addr = s.wbd;
    if_a.mem_req = s.req;    if_a.dmem_ack = s.ack;    if_a.mem_redirect = s.redir;
  endtask

  // Called just after a falling edge; returns the control vectors seen this cycle.
  task automatic cycle(input stim_t s, output logic [8:0] got_a, output logic [8:0] got_b);
    logic [8:0] ea, eb;
    int ca, cb;
    drive(s);
    #1;
    mdl_eval(ma, s, ea, ca);
    mdl_eval(mb, s, eb, cb);
    got_a = ctl_a();
    got_b = ctl_b();
    chk("a_ctl", 32'(got_a), 32'(ea));
    chk("a_state", 32'(if_a.state), 32'(ma.st));
    chk("a_cnt_raw", 32'(if_a.cnt_raw), 32'(ma.craw));
    chk("a_cnt_mem", 32'(if_a.cnt_mem), 32'(ma.cmem));
    chk("a_cnt_flush", 32'(if_a.cnt_flush), 32'(ma.cfl));
    chk("a_tmo_err", 32'(if_a.mem_tmo_err), 32'(ma.err));
    chk("b_ctl", 32'(got_b), 32'(eb));
    chk("b_state", 32'(if_b.state), 32'(mb.st));
    chk("b_cnt_raw", 32'(if_b.cnt_raw), 32'(mb.craw));
    chk("b_cnt_mem", 32'(if_b.cnt_mem), 32'(mb.cmem));
    chk("b_cnt_flush", 32'(if_b.cnt_flush), 32'(mb.cfl));
    chk("b_tmo_err", 32'(if_b.mem_tmo_err), 32'(mb.err));
    ma = mdl_next(ma, s, ca);
    mb = mdl_next(mb, s, cb);
    @(negedge clk);
  endtask

  initial begin
    vec_t vt[$];
    stim_t idle, s;
    logic [8:0] ga, gb;

    idle = mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    vt.push_back('{mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0), C_RUN, C_RUN, "idle"});
    vt.push_back('{mk(0, 1,3,1,0,0, 1,1,3, 0,0,0, 0,0,0, 0,0,0), C_RAW, C_RAW, "ex_rs"});
    vt.push_back('{mk(0, 1,0,1,0,1, 1,1,0, 1,1,0, 1,1,0, 0,0,0), C_RUN, C_RUN, "r0"});
    vt.push_back('{mk(0, 1,1,0,5,1, 0,0,0, 1,1,5, 0,0,0, 0,0,0), C_RAW, C_RAW, "mem_rt"});
    vt.push_back('{mk(0, 1,7,1,0,0, 0,0,0, 0,0,0, 1,1,7, 0,0,0), C_RUN, C_RAW, "wb_rs"});
    vt.push_back('{mk(0, 1,0,0,3,0, 1,1,3, 0,0,0, 0,0,0, 0,0,0), C_RUN, C_RUN, "rt_unused"});
    vt.push_back('{mk(0, 0,3,1,3,1, 1,1,3, 0,0,0, 0,0,0, 0,0,0), C_RUN, C_RUN, "id_invalid"});
    vt.push_back('{mk(0, 1,3,1,0,0, 1,0,3, 0,0,0, 0,0,0, 0,0,0), C_RUN, C_RUN, "ex_no_wen"});
    vt.push_back('{mk(0, 0,0,0,0,0, 0,0,0, 1,1,2, 0,0,0, 1,1,0), C_RUN, C_RUN, "ack_same"});
    vt.push_back('{mk(0, 0,0,0,0,0, 0,0,0, 1,1,2, 0,0,0, 1,0,0), C_MEM, C_MEM, "mem_wait"});
    vt.push_back('{mk(0, 1,3,1,0,0, 1,1,3, 0,0,0, 0,0,0, 0,0,1), C_RED, C_RED, "redir_raw"});
    vt.push_back('{mk(0, 1,3,1,0,0, 1,1,3, 1,1,2, 0,0,0, 1,0,1), C_MEM, C_MEM, "wait_redir"});
    vt.push_back('{mk(1, 1,3,1,0,0, 1,1,3, 1,1,2, 0,0,0, 1,0,1), C_RST, C_RST, "rst_held"});

    // Bring both instances out of an unknown power-up state before the model takes over.
    drive(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    @(negedge clk);
    @(negedge clk);
    ma = mdl_init(1, 16, 16);
    mb = mdl_init(0, 4, 4);

    cycle(idle, ga, gb);
    chk("reset_state", 32'(if_a.state), 32'd0);
    chk("reset_cnt_raw", 32'(if_a.cnt_raw), 32'd0);
    chk("reset_err", 32'(if_a.mem_tmo_err), 32'd0);

    foreach (vt[i]) begin
      cycle(vt[i].s, ga, gb);
      chk({"vec_a_", vt[i].name}, 32'(ga), 32'(vt[i].exp_a));
      chk({"vec_b_", vt[i].name}, 32'(gb), 32'(vt[i].exp_b));
    end

    // RAW on r3 following the producer down the pipe: EX, MEM, then WB.
    cycle(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0), ga, gb);
    cycle(mk(0, 1,3,1,0,0, 1,1,3, 0,0,0, 0,0,0, 0,0,0), ga, gb);
    chk("raw_ex", 32'(ga), 32'(C_RAW));
    cycle(mk(0, 1,3,1,0,0, 0,0,0, 1,1,3, 0,0,0, 0,0,0), ga, gb);
    chk("raw_mem", 32'(ga), 32'(C_RAW));
    cycle(mk(0, 1,3,1,0,0, 0,0,0, 0,0,0, 1,1,3, 0,0,0), ga, gb);
    chk("raw_wb_a", 32'(ga), 32'(C_RUN));
    chk("raw_wb_b", 32'(gb), 32'(C_RAW));
    cycle(idle, ga, gb);
    chk("raw_cnt_a", 32'(if_a.cnt_raw), 32'd2);
    chk("raw_cnt_b", 32'(if_b.cnt_raw), 32'd3);

    // Load acknowledged after three wait cycles.
    cycle(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0), ga, gb);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(0, 0,0,0,0,0, 0,0,0, 1,1,4, 0,0,0, 1,0,0), ga, gb);
      chk("lw_wait", 32'(ga), 32'(C_MEM));
    end
    cycle(mk(0, 0,0,0,0,0, 0,0,0, 1,1,4, 0,0,0, 1,1,0), ga, gb);
    chk("lw_ack", 32'(ga), 32'(C_RUN));
    chk("lw_cnt_mem", 32'(if_a.cnt_mem), 32'd3);
    chk("lw_err", 32'(if_a.mem_tmo_err), 32'd0);

    // Memory never acknowledges: 15 stall cycles, then forced release.
    cycle(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0), ga, gb);
    for (int i = 0; i < 16; i++) begin
      cycle(mk(0, 0,0,0,0,0, 0,0,0, 1,1,4, 0,0,0, 1,0,0), ga, gb);
      chk("tmo_seq", 32'(ga), 32'((i < 15) ? C_MEM : C_RUN));
    end
    cycle(idle, ga, gb);
    chk("tmo_cnt_mem", 32'(if_a.cnt_mem), 32'd15);
    chk("tmo_err_set", 32'(if_a.mem_tmo_err), 32'd1);
    for (int i = 0; i < 5; i++) cycle(idle, ga, gb);
    chk("tmo_err_sticky", 32'(if_a.mem_tmo_err), 32'd1);

    // Redirect wins over a simultaneous RAW.
    cycle(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0), ga, gb);
    cycle(mk(0, 1,3,1,0,0, 1,1,3, 0,0,0, 0,0,0, 0,0,1), ga, gb);
    chk("redir_ctl", 32'(ga), 32'(C_RED));
    cycle(idle, ga, gb);
    chk("redir_cnt_flush", 32'(if_a.cnt_flush), 32'd1);
    chk("redir_cnt_raw", 32'(if_a.cnt_raw), 32'd0);

    // 20 RAW cycles saturate the 4-bit counter; then reset in the middle of a memory wait.
    for (int i = 0; i < 20; i++) cycle(mk(0, 1,3,1,0,0, 1,1,3, 0,0,0, 0,0,0, 0,0,0), ga, gb);
    cycle(idle, ga, gb);
    chk("sat_cnt_b", 32'(if_b.cnt_raw), 32'd15);
    chk("sat_cnt_a", 32'(if_a.cnt_raw), 32'd20);
    for (int i = 0; i < 2; i++) cycle(mk(0, 0,0,0,0,0, 0,0,0, 1,1,4, 0,0,0, 1,0,0), ga, gb);
    chk("mid_wait_state", 32'(if_a.state), 32'd2);
    cycle(mk(1, 0,0,0,0,0, 0,0,0, 1,1,4, 0,0,0, 1,0,0), ga, gb);
    chk("rst_ctl", 32'(ga), 32'(C_RST));
    cycle(idle, ga, gb);
    chk("rst_state", 32'(if_a.state), 32'd0);
    chk("rst_cnt_raw_b", 32'(if_b.cnt_raw), 32'd0);
    chk("rst_cnt_mem_a", 32'(if_a.cnt_mem), 32'd0);
    chk("rst_ctl_after", 32'(ga), 32'(C_RUN));

    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(63) == 0);
      s.idv   = 1'($urandom);
      s.rs    = 5'($urandom_range(3));
      s.rsu   = 1'($urandom);
      s.rt    = 5'($urandom_range(3));
      s.rtu   = 1'($urandom);
      s.exv   = 1'($urandom);
      s.exw   = 1'($urandom);
      s.exd   = 5'($urandom_range(3));
      s.memv  = ($urandom_range(7) != 0);
      s.memw  = 1'($urandom);
      s.memd  = 5'($urandom_range(3));
      s.wbv   = 1'($urandom);
      s.wbw   = 1'($urandom);
      s.wbd   = 5'($urandom_range(3));
      s.req   = ($urandom_range(7) != 0);
      s.ack   = ($urandom_range(5) == 0);
      s.redir = ($urandom_range(7) == 0);
      cycle(s, ga, gb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
